accel_smoother: RTL and testbench

Conditions the raw 9-bit accelerometer X/Y samples from the accelerometer controller before they reach the processor's player-position inputs. It sits between the accelerometer controller and the CPU's piped position inputs. Per axis, it:
- decimates the continuously updating raw values to a fixed sample rate,
- applies a power-of-two moving-average filter,
- suppresses small jitter with a deadband.

The game loop reads steady, de-noised player coordinates and gets a one-cycle strobe for each new filtered sample.

---
 rtl/accel_smoother.sv | 103 ++++++++++
 tb/tb_accel_smoother.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/accel_smoother.sv
// ============================================================================
// accel_smoother : decimate, moving-average and deadband-filter 9-bit X/Y samples
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module accel_smoother #(
   parameter int SAMPLE_DIV = 500000,
   parameter int LOG2_DEPTH = 3,
   parameter int DEADBAND   = 2
) (
   input  logic       clock,
   input  logic       anti_reset,
   input  logic [8:0] accel_x_raw,
   input  logic [8:0] accel_y_raw,
   input  logic       hold,
   output logic [8:0] x_out,
   output logic [8:0] y_out,
   output logic       sample_valid
);

   localparam int                  DEPTH       = 1 << LOG2_DEPTH;
   localparam int                  SUM_W       = 9 + LOG2_DEPTH;
   localparam logic [23:0]         C_TICK_LAST = 24'(SAMPLE_DIV - 1);
   localparam logic [8:0]          C_MID       = 9'd256;
   localparam logic [8:0]          C_DEADBAND  = 9'(DEADBAND);
   localparam logic [SUM_W-1:0]    C_SUM_RST   = {C_MID, {LOG2_DEPTH{1'b0}}};
   localparam logic [LOG2_DEPTH-1:0] C_PTR_ONE = LOG2_DEPTH'(1);

   logic [23:0]           tick_cnt_q, tick_cnt_d;
   logic                  tick;
   logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;
   logic                  v1_q, v2_q, valid_q;

   always_comb begin
      tick       = (tick_cnt_q == C_TICK_LAST);
      tick_cnt_d = tick ? 24'd0 : tick_cnt_q + 24'd1;
      ptr_d      = tick ? ptr_q + C_PTR_ONE : ptr_q;
   end

   // v1/v2 track a sample through stages 2 and 3 so reset discards in-flight work.
   always_ff @(posedge clock or negedge anti_reset) begin
      if (!anti_reset) begin
         tick_cnt_q <= 24'd0;
         ptr_q      <= '0;
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         ptr_q      <= ptr_d;
         v1_q       <= tick;
         v2_q       <= v1_q;
         valid_q    <= v2_q && !hold;
      end
   end

   genvar a;
   generate
      for (a = 0; a < 2; a++) begin : g_axis
         logic [8:0]       raw;
         logic [8:0]       ring_q [DEPTH];
         logic [8:0]       new_q, old_q;
         logic [SUM_W-1:0] sum_q, sum_d;
         logic [8:0]       avg, diff, out_q, out_d;

         assign raw = (a == 0) ? accel_x_raw : accel_y_raw;

         always_comb begin
            sum_d = sum_q + SUM_W'(new_q) - SUM_W'(old_q);
            avg   = sum_q[SUM_W-1:LOG2_DEPTH];
            diff  = (avg >= out_q) ? (avg - out_q) : (out_q - avg);
            out_d = (v2_q && !hold && (diff >= C_DEADBAND)) ? avg : out_q;
         end

         always_ff @(posedge clock or negedge anti_reset) begin
            if (!anti_reset) begin
               for (int i = 0; i < DEPTH; i++) ring_q[i] <= C_MID;
               new_q <= C_MID;
               old_q <= C_MID;
               sum_q <= C_SUM_RST;
               out_q <= C_MID;
            end else begin
               if (tick) begin
                  new_q         <= raw;
                  old_q         <= ring_q[ptr_q];
                  ring_q[ptr_q] <= raw;
               end
               if (v1_q) sum_q <= sum_d;
               out_q <= out_d;
            end
         end
      end
   endgenerate

   assign x_out        = g_axis[0].out_q;
   assign y_out        = g_axis[1].out_q;
   assign sample_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_accel_smoother.sv
// Directed bench for accel_smoother with SAMPLE_DIV=4, LOG2_DEPTH=3, DEADBAND=2.
`timescale 1ns/1ps
`default_nettype none

module tb_accel_smoother;

   logic       clock = 1'b0;
   logic       anti_reset = 1'b0;
   logic [8:0] accel_x_raw = 9'd100;
   logic [8:0] accel_y_raw = 9'd400;
   logic       hold = 1'b0;
   logic [8:0] x_out, y_out;
   logic       sample_valid;

   int checks   = 0;
   int failures = 0;
   int n;

   accel_smoother #(
      .SAMPLE_DIV(4),
      .LOG2_DEPTH(3),
      .DEADBAND  (2)
   ) dut (
      .clock       (clock),
      .anti_reset  (anti_reset),
      .accel_x_raw (accel_x_raw),
      .accel_y_raw (accel_y_raw),
      .hold        (hold),
      .x_out       (x_out),
      .y_out       (y_out),
      .sample_valid(sample_valid)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Advance until sample_valid is seen (or budget expires); returns cycles taken.
   task automatic wait_valid(input int budget, output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!sample_valid && cycles < budget);
      chk("valid_seen", {31'd0, sample_valid}, 32'd1);
   endtask

   initial begin
      // Reset held with non-midpoint inputs
      for (int i = 0; i < 20; i++) begin
         step();
         chk("rst_x", x_out, 256);
         chk("rst_y", y_out, 256);
         chk("rst_valid", {31'd0, sample_valid}, 0);
      end

      // Step response X=300, Y=200
      accel_x_raw = 9'd300;
      accel_y_raw = 9'd200;
      anti_reset  = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         wait_valid(10, n);
         chk(k == 1 ? "first_latency" : "step_interval", n, k == 1 ? 6 : 4);
         chk("step_x", x_out, 256 + (44 * k) / 8);
         chk("step_y", y_out, 256 - (56 * k + 7) / 8);
      end
      for (int k = 0; k < 3; k++) begin
         wait_valid(8, n);
         chk("steady_x", x_out, 300);
         chk("steady_y", y_out, 200);
      end

      // Deadband: settle at 256 then alternate 257/256
      accel_x_raw = 9'd256;
      accel_y_raw = 9'd256;
      for (int k = 0; k < 8; k++) wait_valid(8, n);
      chk("settle_x", x_out, 256);
      chk("settle_y", y_out, 256);
      for (int i = 0; i < 8; i++) begin
         accel_x_raw = (i % 2 == 0) ? 9'd257 : 9'd256;
         wait_valid(8, n);
         chk("db_interval", n, 4);
         chk("db_x", x_out, 256);
      end

      // Ring wrap: ramp X = 256 + 8k
      accel_x_raw = 9'd256;
      for (int k = 0; k < 8; k++) wait_valid(8, n);
      for (int k = 0; k < 20; k++) begin
         accel_x_raw = 9'(256 + 8 * k);
         wait_valid(8, n);
         if (k >= 7) chk("ramp_x", x_out, 256 + 8 * k - 28);
      end

      // Hold: outputs frozen, no strobes, filter keeps running
      accel_x_raw = 9'd256;
      for (int k = 0; k < 8; k++) wait_valid(8, n);
      chk("prehold_x", x_out, 256);
      hold        = 1'b1;
      accel_x_raw = 9'd400;
      for (int i = 0; i < 40; i++) begin
         step();
         chk("hold_frozen", {22'd0, x_out, sample_valid}, {22'd0, 9'd256, 1'b0});
      end
      hold = 1'b0;
      wait_valid(8, n);
      chk("release_x", x_out, 400);
      chk("release_y", y_out, 256);

      // Asynchronous reset between a capture and its output edge
      accel_x_raw = 9'd100;
      wait_valid(8, n);
      step();
      step();
      anti_reset = 1'b0;
      #1;
      chk("midrst_x", x_out, 256);
      chk("midrst_valid", {31'd0, sample_valid}, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("midrst_nostray", {31'd0, sample_valid}, 0);
      end
      anti_reset = 1'b1;
      wait_valid(10, n);
      chk("postrst_latency", n, 6);
      chk("postrst_x", x_out, 236);
      chk("postrst_y", y_out, 256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
